// File: rtl/mpu_pkg.sv
// Shared types and constants for the IMU burst collector.
// Holds the collector state encoding, the IMU register map entries the
// collector cares about, the burst geometry and the output word layout.
package mpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_COLLECT = 3'd2,
        S_PUBLISH = 3'd3,
        S_ABORT   = 3'd4
    } mpu_state_e;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] WHO_AM_I     = 8'h75;

    localparam int unsigned MPU_BURST_LEN = 14;
    localparam int unsigned NUM_WORDS     = MPU_BURST_LEN / 2;

    // Position of each 16-bit word in the measurement block.
    localparam int unsigned W_AX   = 0;
    localparam int unsigned W_AY   = 1;
    localparam int unsigned W_AZ   = 2;
    localparam int unsigned W_TEMP = 3;
    localparam int unsigned W_GX   = 4;
    localparam int unsigned W_GY   = 5;
    localparam int unsigned W_GZ   = 6;

    // True for register addresses this block knows about.
    function automatic logic is_known_reg(input logic [7:0] addr);
        return (addr == ACCEL_XOUT_H) || (addr == PWR_MGMT_1) || (addr == WHO_AM_I);
    endfunction

endpackage

// File: rtl/mpu_burst_collector_if.sv
// Bus bundle between the I2C master, the burst collector and the filter stage.
// master : collector side (drives read requests and the assembled sample)
// slave  : environment side (I2C master byte stream and sample consumer)
interface mpu_burst_collector_if;

    // Read request towards the I2C master
    logic               rd_req;
    logic [7:0]         rd_reg_addr;
    logic [3:0]         rd_len;
    logic               rd_ack;
    // Received byte stream
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_last;
    logic               bus_err;
    // Assembled sample towards the filter stage
    logic               sample_valid;
    logic               sample_ready;
    logic signed [15:0] accel_x;
    logic signed [15:0] accel_y;
    logic signed [15:0] accel_z;
    logic signed [15:0] temp;
    logic signed [15:0] gyro_x;
    logic signed [15:0] gyro_y;
    logic signed [15:0] gyro_z;
    logic               sample_err;
    logic [7:0]         err_cnt;
    logic [7:0]         overrun_cnt;

    modport master (
        output rd_req, rd_reg_addr, rd_len,
        input  rd_ack,
        input  byte_valid, byte_data, byte_last, bus_err,
        output sample_valid,
        input  sample_ready,
        output accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z,
        output sample_err, err_cnt, overrun_cnt
    );

    modport slave (
        input  rd_req, rd_reg_addr, rd_len,
        output rd_ack,
        output byte_valid, byte_data, byte_last, bus_err,
        input  sample_valid,
        output sample_ready,
        input  accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z,
        input  sample_err, err_cnt, overrun_cnt
    );

endinterface

// File: rtl/mpu_tick_gen.sv
// Free-running sample period timer.
// Ports: clk, rst (async, active high); tick_o is a registered one-cycle
// pulse every PERIOD cycles, high while the counter sits at zero.
module mpu_tick_gen #(
    parameter int unsigned PERIOD = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Count down, reload on zero; flag the cycle in which the count is zero.
    always_comb begin
        cnt_d  = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
        tick_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= RELOAD;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/mpu_burst_collector.sv
// Schedules periodic 14-byte IMU burst reads, assembles the returned bytes
// into seven big-endian signed words and hands them on via valid/ready.
// Ports: clk, rst (async, active high); bus (master modport) carrying the
// read request, received byte stream, sample handshake, words and counters.
module mpu_burst_collector
    import mpu_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD  = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  START_REG      = ACCEL_XOUT_H,
    parameter int unsigned BURST_LEN      = MPU_BURST_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    mpu_burst_collector_if.master bus
);

    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_IDX = 4'(BURST_LEN - 1);

    mpu_state_e    state_q, state_d;
    logic          pending_q, pending_d;
    logic [7:0]    overrun_q, overrun_d;
    logic [7:0]    err_q, err_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    shadow_q [MPU_BURST_LEN];
    logic [7:0]    shadow_d [MPU_BURST_LEN];
    logic [15:0]   word_q   [NUM_WORDS];
    logic [15:0]   word_d   [NUM_WORDS];
    logic          rd_req_q, rd_req_d;
    logic          valid_q, valid_d;
    logic          serr_q, serr_d;
    logic          tick;
    logic          consume;

    mpu_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        err_d     = err_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        shadow_d  = shadow_q;
        word_d    = word_q;
        consume   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    consume = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.bus_err) begin
                    state_d = S_ABORT;
                end else if (rd_req_q && bus.rd_ack) begin
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A bus error discards any byte presented in the same cycle.
                if (bus.bus_err) begin
                    state_d = S_ABORT;
                end else if (bus.byte_valid) begin
                    tmo_d           = '0;
                    shadow_d[idx_q] = bus.byte_data;
                    idx_d           = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        if (bus.byte_last) begin
                            state_d = S_PUBLISH;
                            for (int k = 0; k < NUM_WORDS; k++) begin
                                word_d[k] = {shadow_d[2*k], shadow_d[2*k+1]};
                            end
                        end else begin
                            state_d = S_ABORT;
                        end
                    end else if (bus.byte_last) begin
                        state_d = S_ABORT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_PUBLISH: begin
                if (valid_q && bus.sample_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Single-deep tick queue; a tick that finds it still occupied is dropped.
        pending_d = tick | (pending_q & ~consume);
        if (tick && pending_q && !consume && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        if ((state_d == S_ABORT) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        rd_req_d = (state_d == S_REQ);
        valid_d  = (state_d == S_PUBLISH);
        serr_d   = (state_d == S_ABORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            overrun_q <= '0;
            err_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            shadow_q  <= '{default: '0};
            word_q    <= '{default: '0};
            rd_req_q  <= 1'b0;
            valid_q   <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            shadow_q  <= shadow_d;
            word_q    <= word_d;
            rd_req_q  <= rd_req_d;
            valid_q   <= valid_d;
            serr_q    <= serr_d;
        end
    end

    assign bus.rd_req       = rd_req_q;
    assign bus.rd_reg_addr  = START_REG;
    assign bus.rd_len       = 4'(BURST_LEN);
    assign bus.sample_valid = valid_q;
    assign bus.sample_err   = serr_q;
    assign bus.err_cnt      = err_q;
    assign bus.overrun_cnt  = overrun_q;
    assign bus.accel_x      = word_q[W_AX];
    assign bus.accel_y      = word_q[W_AY];
    assign bus.accel_z      = word_q[W_AZ];
    assign bus.temp         = word_q[W_TEMP];
    assign bus.gyro_x       = word_q[W_GX];
    assign bus.gyro_y       = word_q[W_GY];
    assign bus.gyro_z       = word_q[W_GZ];

endmodule

// File: tb/tb_mpu_burst_collector.sv
// Directed bench for mpu_burst_collector: nominal burst, backpressure,
// early last, timeout, bus error priority and saturation, async reset.
module tb_mpu_burst_collector;
    import mpu_pkg::*;

    localparam int unsigned SP  = 200;
    localparam int unsigned TMO = 50;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mpu_burst_collector_if bus();

    mpu_burst_collector #(
        .SAMPLE_PERIOD  (SP),
        .TIMEOUT_CYCLES (TMO),
        .START_REG      (8'h3B),
        .BURST_LEN      (14)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait at negedges for rd_req, bounded; n = negedges waited.
    task automatic wait_req(input int max_cyc, output int n);
        n = 0;
        while (!bus.rd_req && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rd_req) check_eq("req_wait", 32'(bus.rd_req), 32'd1);
    endtask

    task automatic ack_now();
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
    endtask

    // Stream n bytes starting at base; last_at is the 1-based byte carrying byte_last (0 = none).
    task automatic send_bytes(input logic [7:0] base, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = base + 8'(i);
            bus.byte_last  = (i + 1 == last_at);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic accept_sample();
        bus.sample_ready = 1'b1;
        @(negedge clk);
        bus.sample_ready = 1'b0;
    endtask

    initial begin
        int          n;
        logic        ok;
        logic [15:0] snap_ax, snap_tp, snap_gz;
        logic [7:0]  ov0, dov;

        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b1;
        bus.rd_ack       = 1'b0;
        bus.byte_valid   = 1'b0;
        bus.byte_data    = 8'h00;
        bus.byte_last    = 1'b0;
        bus.bus_err      = 1'b0;
        bus.sample_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_rd_req", 32'(bus.rd_req), 32'd0);
        check_eq("rst_valid", 32'(bus.sample_valid), 32'd0);
        check_eq("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check_eq("rst_overrun", 32'(bus.overrun_cnt), 32'd0);
        check_eq("rst_accel_x", 32'(16'(bus.accel_x)), 32'h0);
        rst = 1'b0;

        // Nominal: first request after one period, ack after 3 cycles, 14 bytes.
        wait_req(SP + 10, n);
        check_eq("first_req_latency", 32'((n >= int'(SP)) && (n <= int'(SP) + 1)), 32'd1);
        check_eq("req_addr", 32'(bus.rd_reg_addr), 32'h3B);
        check_eq("req_addr_known", 32'(is_known_reg(bus.rd_reg_addr)), 32'd1);
        check_eq("req_len", 32'(bus.rd_len), 32'd14);
        repeat (2) @(negedge clk);
        check_eq("req_held", 32'(bus.rd_req), 32'd1);
        ack_now();
        check_eq("req_dropped", 32'(bus.rd_req), 32'd0);
        send_bytes(8'h01, 13, 0);
        check_eq("nom_not_yet_valid", 32'(bus.sample_valid), 32'd0);
        send_bytes(8'h0E, 1, 1);
        check_eq("nom_valid", 32'(bus.sample_valid), 32'd1);
        check_eq("nom_ax", 32'(16'(bus.accel_x)), 32'h0102);
        check_eq("nom_ay", 32'(16'(bus.accel_y)), 32'h0304);
        check_eq("nom_az", 32'(16'(bus.accel_z)), 32'h0506);
        check_eq("nom_temp", 32'(16'(bus.temp)), 32'h0708);
        check_eq("nom_gx", 32'(16'(bus.gyro_x)), 32'h090A);
        check_eq("nom_gy", 32'(16'(bus.gyro_y)), 32'h0B0C);
        check_eq("nom_gz", 32'(16'(bus.gyro_z)), 32'h0D0E);

        // Backpressure: 500 cycles without ready.
        snap_ax = bus.accel_x;
        snap_tp = bus.temp;
        snap_gz = bus.gyro_z;
        ov0     = bus.overrun_cnt;
        ok      = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (!bus.sample_valid || bus.accel_x != snap_ax || bus.temp != snap_tp
                || bus.gyro_z != snap_gz) ok = 1'b0;
        end
        check_eq("bp_stable", 32'(ok), 32'd1);
        dov = bus.overrun_cnt - ov0;
        check_eq("bp_overrun_1_or_2", 32'((dov >= 8'd1) && (dov <= 8'd2)), 32'd1);
        accept_sample();
        check_eq("bp_valid_drop", 32'(bus.sample_valid), 32'd0);
        wait_req(5, n);
        check_eq("bp_req_prompt", 32'(n <= 3), 32'd1);
        ack_now();
        send_bytes(8'h11, 14, 14);
        check_eq("s2_valid", 32'(bus.sample_valid), 32'd1);
        check_eq("s2_ax", 32'(16'(bus.accel_x)), 32'h1112);
        check_eq("s2_gz", 32'(16'(bus.gyro_z)), 32'h1D1E);
        accept_sample();
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.rd_req) ok = 1'b0;
        end
        check_eq("bp_single_request", 32'(ok), 32'd1);

        // Early last on byte 10.
        wait_req(SP + 10, n);
        ack_now();
        send_bytes(8'h21, 10, 10);
        check_eq("early_serr", 32'(bus.sample_err), 32'd1);
        check_eq("early_err_cnt", 32'(bus.err_cnt), 32'd1);
        check_eq("early_no_valid", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        check_eq("early_serr_pulse", 32'(bus.sample_err), 32'd0);
        check_eq("early_keep_ax", 32'(16'(bus.accel_x)), 32'h1112);
        check_eq("early_keep_gz", 32'(16'(bus.gyro_z)), 32'h1D1E);
        wait_req(SP + 10, n);
        check_eq("early_next_req", 32'(bus.rd_req), 32'd1);

        // Timeout after 5 bytes: error exactly TMO cycles after the 5th byte.
        ack_now();
        send_bytes(8'h31, 5, 0);
        repeat (TMO - 1) @(negedge clk);
        check_eq("tmo_not_early", 32'(bus.sample_err), 32'd0);
        @(negedge clk);
        check_eq("tmo_serr", 32'(bus.sample_err), 32'd1);
        check_eq("tmo_err_cnt", 32'(bus.err_cnt), 32'd2);
        @(negedge clk);
        check_eq("tmo_idle", 32'(dut.state_q), 32'(S_IDLE));

        // bus_err together with the final byte: abort wins, byte not applied.
        wait_req(SP + 10, n);
        ack_now();
        send_bytes(8'h41, 13, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h4E;
        bus.byte_last  = 1'b1;
        bus.bus_err    = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.bus_err    = 1'b0;
        check_eq("berr_serr", 32'(bus.sample_err), 32'd1);
        check_eq("berr_no_valid", 32'(bus.sample_valid), 32'd0);
        check_eq("berr_err_cnt", 32'(bus.err_cnt), 32'd3);
        check_eq("berr_keep_ax", 32'(16'(bus.accel_x)), 32'h1112);

        // 300 more forced errors during REQ: counter saturates.
        for (int i = 0; i < 300; i++) begin
            wait_req(SP + 10, n);
            bus.bus_err = 1'b1;
            @(negedge clk);
            bus.bus_err = 1'b0;
        end
        @(negedge clk);
        check_eq("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

        // Async reset mid-COLLECT, applied between clock edges.
        wait_req(SP + 10, n);
        ack_now();
        send_bytes(8'h51, 4, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_rd_req", 32'(bus.rd_req), 32'd0);
        check_eq("arst_valid", 32'(bus.sample_valid), 32'd0);
        check_eq("arst_serr", 32'(bus.sample_err), 32'd0);
        check_eq("arst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check_eq("arst_overrun", 32'(bus.overrun_cnt), 32'd0);
        check_eq("arst_ax", 32'(16'(bus.accel_x)), 32'h0);
        check_eq("arst_gz", 32'(16'(bus.gyro_z)), 32'h0);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_req(SP + 10, n);
        check_eq("arst_req_latency", 32'((n >= int'(SP)) && (n <= int'(SP) + 1)), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mpu_burst_collector.md
Name: mpu_burst_collector

Overview:
Sits directly downstream of the I2C master. It schedules periodic burst reads of the IMU measurement block (14 bytes from register 0x3B), consumes the byte stream the master returns, and assembles the bytes into seven big-endian signed 16-bit words. The assembled sample is presented to the attitude/filter stage through a valid/ready handshake, and read failures are flagged.

Parameters:
SAMPLE_PERIOD, 100000, clk cycles between scheduled burst reads (must be >= 2)
TIMEOUT_CYCLES, 50000, max clk cycles without an accepted byte while a burst is in flight
START_REG, 8'h3B, first register address of the burst
BURST_LEN, 14, bytes per burst (fixed at 14; other values are unsupported)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rd_req  out  1  burst read request to the I2C master
rd_reg_addr  out  8  register address; equals START_REG whenever rd_req=1
rd_len  out  4  byte count; equals BURST_LEN whenever rd_req=1
rd_ack  in  1  master accepted the request; transfer occurs when rd_req & rd_ack
byte_valid  in  1  one received byte is present this cycle
byte_data  in  8  received byte
byte_last  in  1  marks the final byte of the burst
bus_err  in  1  master reports NACK or arbitration failure (1-cycle pulse)
sample_valid  out  1  assembled sample available
sample_ready  in  1  consumer accepts; transfer occurs when sample_valid & sample_ready
accel_x, accel_y, accel_z  out  16 each  signed accelerometer words
temp  out  16  signed temperature word
gyro_x, gyro_y, gyro_z  out  16 each  signed gyro words
sample_err  out  1  1-cycle pulse when a burst is aborted
err_cnt  out  8  saturating count of aborted bursts
overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Reset (async, any state): state=IDLE. rd_req, sample_valid, sample_err=0. All data words=0. err_cnt, overrun_cnt=0. Tick counter loads SAMPLE_PERIOD-1. Tick-pending flag cleared. Shadow registers and byte index cleared.
- Tick generator: free-running down-counter; on reaching 0 it reloads and sets tick_pending.
  - Tick while tick_pending is already set: overrun_cnt increments, saturating at 255. Pending depth is 1.
- FSM states: IDLE, REQ, COLLECT, PUBLISH, ABORT.
- IDLE: if tick_pending, clear it and go to REQ. byte_valid is ignored.
- REQ: rd_req=1, held until rd_ack. On the ack cycle: rd_req drops next cycle, byte_idx=0, timeout counter cleared, go to COLLECT.
- COLLECT, on each byte_valid:
  - shadow[byte_idx] <= byte_data; byte_idx increments; timeout counter cleared.
  - byte_last on byte_idx<13, or byte_last missing on byte_idx=13 -> ABORT.
  - byte_idx=13 with byte_last -> PUBLISH.
- COLLECT timeout: if TIMEOUT_CYCLES elapse without byte_valid -> ABORT.
- bus_err in REQ or COLLECT -> ABORT. bus_err takes priority over a simultaneous byte.
- Entering PUBLISH, in one cycle: all seven output words load from shadow, where word k = {shadow[2k], shadow[2k+1]}.
  - Order: ax, ay, az, temp, gx, gy, gz.
  - sample_valid=1 the cycle after the last byte is accepted (1-cycle latency).
- PUBLISH: words are stable while sample_valid=1. On sample_valid & sample_ready, sample_valid drops next cycle and the FSM returns to IDLE.
  - Ticks arriving during PUBLISH stay pending; a second one counts as overrun.
- ABORT (one cycle): sample_err=1; err_cnt increments, saturating at 255; shadow is discarded and the outputs keep the previous sample; go to IDLE.
- Simultaneous tick and handshake completion: the tick is captured as pending and serviced from IDLE next cycle.

Decomposition:
- Package mpu_pkg:
  - State enum.
  - Register constants: ACCEL_XOUT_H=8'h3B, PWR_MGMT_1=8'h6B, WHO_AM_I=8'h75.
  - BURST_LEN.
  - Word index constants.
- One sub-module, mpu_tick_gen: period counter plus tick pulse; the pending flag stays in the parent.

Test Plan:
- Nominal: SAMPLE_PERIOD=200, ack after 3 cycles, stream bytes 0x01..0x0E with last on the 14th -> sample_valid 1 cycle later; accel_x=16'h0102, temp=16'h0708, gyro_z=16'h0D0E.
- Backpressure: hold sample_ready=0 for 500 cycles with SAMPLE_PERIOD=200 -> words stable throughout; overrun_cnt=1 or 2 per elapsed ticks; exactly one request after release.
- Early last: byte_last on the 10th byte -> sample_err pulse; err_cnt=1; outputs keep the previous sample; next tick issues a new rd_req.
- Timeout: TIMEOUT_CYCLES=50, stop after 5 bytes -> sample_err exactly 50 cycles after the 5th byte; FSM back in IDLE.
- bus_err coinciding with byte_valid in COLLECT -> abort, byte not applied, err_cnt increments; 300 forced errors -> err_cnt saturates at 255.
- Async rst asserted mid-COLLECT, off a clock edge -> all outputs 0 immediately; after release, the first rd_req comes SAMPLE_PERIOD cycles later.
